// File: rtl/ir_nec_transmitter_if.sv
// Handshake/bus bundle for ir_nec_transmitter.
// The repeat_req signal exists only when IR_TX_REPEAT_EN is defined.
interface ir_nec_tx_if;
  logic        start;
  logic [31:0] data;
`ifdef IR_TX_REPEAT_EN
  logic        repeat_req;
`endif
  logic        busy;
  logic        done;
  logic        ir_envelope;
  logic        ir_tx;

`ifdef IR_TX_REPEAT_EN
  modport master (output start, data, repeat_req, input busy, done, ir_envelope, ir_tx);
  modport slave  (input start, data, repeat_req, output busy, done, ir_envelope, ir_tx);
`else
  modport master (output start, data, input busy, done, ir_envelope, ir_tx);
  modport slave  (input start, data, output busy, done, ir_envelope, ir_tx);
`endif
endinterface

// File: rtl/ir_nec_transmitter.sv
// NEC IR transmitter: serialises a 32-bit code LSB-first into NEC mark/space
// timing and drives a carrier-modulated LED output.
// Optional macro IR_TX_REPEAT_EN adds the NEC repeat-code frame (repeat_req).
//
// state      | meaning
// IDLE       | waiting for start (busy=0)
// LEAD_MARK  | 16-unit leader mark
// LEAD_SPACE | 8-unit leader space
// BIT_MARK   | 1-unit mark before each data bit
// BIT_SPACE  | 1 unit (bit=0) or 3 units (bit=1) of space
// REP_SPACE  | 4-unit space of a repeat code (IR_TX_REPEAT_EN only)
// STOP_MARK  | 1-unit trailing mark
// GAP        | GAP_UNITS of enforced idle; done pulses on exit
module ir_nec_transmitter #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439,
  parameter int GAP_UNITS    = 40
) (
  input  logic         clk_50,
  input  logic         resend,
  ir_nec_tx_if.slave   bus
);

  localparam int MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int UW = $clog2(MAX_UNITS + 1);
  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int KW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
`ifdef IR_TX_REPEAT_EN
    REP_SPACE,
`endif
    STOP_MARK,
    GAP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cyc_cnt;
  logic [UW-1:0] unit_cnt;
  logic [UW-1:0] last_unit;
  logic [4:0]    bit_idx;
  logic [31:0]   data_q;
  logic [KW-1:0] car_cnt, car_nxt;
  logic          unit_end;
  logic          accept;
  logic          mark_nxt;
  logic          busy_q, done_q, env_q, tx_q;
`ifdef IR_TX_REPEAT_EN
  logic          rep_q;
`endif

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ir_envelope = env_q;
  assign bus.ir_tx       = tx_q;

  // State register.
  always_ff @(posedge clk_50 or posedge resend) begin
    if (resend) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: each state lasts last_unit+1 units of UNIT_CYCLES clocks.
  always_comb begin
    state_nxt = state;
    last_unit = '0;
    accept    = 1'b0;
    unit_end  = 1'b0;
    case (state)
      LEAD_MARK:  last_unit = UW'(15);
      LEAD_SPACE: last_unit = UW'(7);
      BIT_SPACE:  last_unit = data_q[bit_idx] ? UW'(2) : UW'(0);
`ifdef IR_TX_REPEAT_EN
      REP_SPACE:  last_unit = UW'(3);
`endif
      GAP:        last_unit = UW'(GAP_UNITS - 1);
      default:    last_unit = '0;
    endcase
    unit_end = (cyc_cnt == CW'(UNIT_CYCLES - 1)) && (unit_cnt == last_unit);
    case (state)
      IDLE: begin
`ifdef IR_TX_REPEAT_EN
        if (bus.start || bus.repeat_req) begin
`else
        if (bus.start) begin
`endif
          accept    = 1'b1;
          state_nxt = LEAD_MARK;
        end
      end
      LEAD_MARK: if (unit_end) begin
`ifdef IR_TX_REPEAT_EN
        state_nxt = rep_q ? REP_SPACE : LEAD_SPACE;
`else
        state_nxt = LEAD_SPACE;
`endif
      end
      LEAD_SPACE: if (unit_end) state_nxt = BIT_MARK;
      BIT_MARK:   if (unit_end) state_nxt = BIT_SPACE;
      BIT_SPACE:  if (unit_end) state_nxt = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
`ifdef IR_TX_REPEAT_EN
      REP_SPACE:  if (unit_end) state_nxt = STOP_MARK;
`endif
      STOP_MARK:  if (unit_end) state_nxt = GAP;
      GAP:        if (unit_end) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Carrier phase restarts on entry to any mark so each mark begins high.
  always_comb begin
    mark_nxt = (state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) || (state_nxt == STOP_MARK);
    if (mark_nxt && (state_nxt != state))  car_nxt = '0;
    else if (car_cnt == KW'(CARRIER_DIV - 1)) car_nxt = '0;
    else                                      car_nxt = car_cnt + 1'b1;
  end

  // Unit timing and bit position; both counters restart on every state change.
  always_ff @(posedge clk_50 or posedge resend) begin
    if (resend) begin
      cyc_cnt  <= '0;
      unit_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      if (state_nxt != state) begin
        cyc_cnt  <= '0;
        unit_cnt <= '0;
      end else if (state != IDLE) begin
        if (cyc_cnt == CW'(UNIT_CYCLES - 1)) begin
          cyc_cnt  <= '0;
          unit_cnt <= unit_cnt + 1'b1;
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end
      if (accept)
        bit_idx <= '0;
      else if (state == BIT_SPACE && state_nxt == BIT_MARK)
        bit_idx <= bit_idx + 1'b1;
    end
  end

  // Latch the code on a data frame; a repeat frame leaves data_q untouched.
  always_ff @(posedge clk_50 or posedge resend) begin
    if (resend) begin
      data_q <= '0;
`ifdef IR_TX_REPEAT_EN
      rep_q  <= 1'b0;
`endif
    end else if (accept) begin
`ifdef IR_TX_REPEAT_EN
      rep_q <= !bus.start;
      if (bus.start) data_q <= bus.data;
`else
      data_q <= bus.data;
`endif
    end
  end

  // Registered outputs derived from the next state so they line up with it.
  always_ff @(posedge clk_50 or posedge resend) begin
    if (resend) begin
      car_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      env_q   <= 1'b0;
      tx_q    <= 1'b0;
    end else begin
      car_cnt <= car_nxt;
      busy_q  <= (state_nxt != IDLE);
      done_q  <= (state == GAP) && (state_nxt == IDLE);
      env_q   <= mark_nxt;
      tx_q    <= mark_nxt && (car_nxt < KW'(CARRIER_HIGH));
    end
  end

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Self-checking bench for ir_nec_transmitter with short timing parameters.
module tb_ir_nec_transmitter;
  localparam int UNIT = 10;
  localparam int GAPC = 20;

  logic clk_50 = 1'b0;
  logic resend;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q[$];
  bit   env_log[0:2047];

  ir_nec_tx_if io();

  ir_nec_transmitter #(
    .UNIT_CYCLES(10), .CARRIER_DIV(4), .CARRIER_HIGH(1), .GAP_UNITS(2)
  ) dut (
    .clk_50(clk_50),
    .resend(resend),
    .bus(io)
  );

  always #5 clk_50 = ~clk_50;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Frame length in cycles without the gap.
  function automatic int frame_len(input logic [31:0] d, input bit rep);
    int t;
    if (rep) return 21 * UNIT;
    t = 24 * UNIT;
    for (int i = 0; i < 32; i++) t += d[i] ? 4 * UNIT : 2 * UNIT;
    return t + UNIT;
  endfunction

  // Reference envelope: env=1 inside a mark, moff = cycle offset within that mark.
  function automatic void model(input logic [31:0] d, input bit rep, input int k,
                                output bit env, output int moff);
    int s;
    env = 0; moff = 0;
    if (k >= 1 && k <= 16 * UNIT) begin env = 1; moff = k - 1; return; end
    if (rep) begin
      if (k >= 20 * UNIT + 1 && k <= 21 * UNIT) begin env = 1; moff = k - 20 * UNIT - 1; end
      return;
    end
    s = 24 * UNIT + 1;
    for (int i = 0; i < 32; i++) begin
      if (k >= s && k < s + UNIT) begin env = 1; moff = k - s; return; end
      s += d[i] ? 4 * UNIT : 2 * UNIT;
    end
    if (k >= s && k < s + UNIT) begin env = 1; moff = k - s; end
  endfunction

  function automatic logic [31:0] decode(input int t);
    int runs[$];
    int r = 0;
    logic [31:0] v = '0;
    for (int k = 1; k <= t; k++) begin
      if (!env_log[k]) r++;
      else if (r > 0) begin runs.push_back(r); r = 0; end
    end
    for (int i = 0; i < 32; i++)
      if (i + 1 < runs.size()) v[i] = (runs[i + 1] > 2 * UNIT);
    return v;
  endfunction

  task automatic start_frame(input logic [31:0] d);
    @(negedge clk_50);
    io.start = 1'b1;
    io.data  = d;
    exp_q.push_back(d);
    @(posedge clk_50);
    #1 io.start = 1'b0;
  endtask

  // Watches one frame from cycle 1 through the done cycle, comparing every cycle
  // against the model. Optional: spurious start at 300, chained start in the
  // done cycle, reset at cycle abort_at.
  task automatic watch_frame(input logic [31:0] d, input bit rep, input bit ign,
                             input bit chain, input logic [31:0] nd, input int abort_at);
    int t, moff, e_env, e_tx, e_busy, e_done;
    bit env, etx;
    logic [31:0] sd;
    t = frame_len(d, rep) + GAPC;
    e_env = 0; e_tx = 0; e_busy = 0; e_done = 0;
    for (int k = 1; k <= t + 1; k++) begin
      @(negedge clk_50);
      if (k == abort_at) begin
        resend = 1'b1;
        #1;
        check_val("rst_busy", io.busy, 0);
        check_val("rst_env", io.ir_envelope, 0);
        check_val("rst_tx", io.ir_tx, 0);
        check_val("rst_done", io.done, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        return;
      end
      model(d, rep, k, env, moff);
      etx = env && (moff % 4 == 0);
      env_log[k] = io.ir_envelope;
      if (io.ir_envelope !== env) e_env++;
      if (io.ir_tx !== etx) e_tx++;
      if (io.busy !== (k <= t)) e_busy++;
      if (io.done !== (k == t + 1)) e_done++;
      if (io.done === 1'b1 && !rep) begin
        if (exp_q.size() == 0) check_val("sb_empty", 1, 0);
        else begin
          sd = exp_q.pop_front();
          check_val("decode", decode(t), sd);
        end
      end
      if (ign && k == 300) begin io.start = 1'b1; io.data = 32'hFFFF_FFFF; end
      if (ign && k == 301) io.start = 1'b0;
      if (chain && k == t + 1) begin
        io.start = 1'b1;
        io.data  = nd;
        exp_q.push_back(nd);
      end
    end
    check_val("env_err", e_env, 0);
    check_val("tx_err", e_tx, 0);
    check_val("busy_err", e_busy, 0);
    check_val("done_err", e_done, 0);
  endtask

  initial begin
    int n;
    resend   = 1'b1;
    io.start = 1'b0;
    io.data  = '0;
`ifdef IR_TX_REPEAT_EN
    io.repeat_req = 1'b0;
`endif
    repeat (3) @(negedge clk_50);
    check_val("rst_busy0", io.busy, 0);
    check_val("rst_done0", io.done, 0);
    check_val("rst_env0", io.ir_envelope, 0);
    check_val("rst_tx0", io.ir_tx, 0);
    resend = 1'b0;
    n = 0;
    repeat (100) begin
      @(negedge clk_50);
      if (io.busy || io.done || io.ir_envelope || io.ir_tx) n++;
    end
    check_val("idle", n, 0);

    // All-zero frame with an ignored start; next frame chained in the done cycle.
    start_frame(32'h0);
    watch_frame(32'h0, 0, 1, 1, 32'h1, 0);
    @(posedge clk_50);
    #1 io.start = 1'b0;
    watch_frame(32'h1, 0, 0, 0, 0, 0);

    start_frame(32'hF708_FB04);
    watch_frame(32'hF708_FB04, 0, 0, 0, 0, 0);

    // Reset mid-frame: outputs drop at once and no done follows.
    start_frame(32'h0);
    watch_frame(32'h0, 0, 0, 0, 0, 500);
    repeat (3) @(negedge clk_50);
    resend = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk_50);
      if (io.done || io.busy) n++;
    end
    check_val("no_done", n, 0);
    start_frame(32'h0);
    watch_frame(32'h0, 0, 0, 0, 0, 0);

`ifdef IR_TX_REPEAT_EN
    @(negedge clk_50);
    io.repeat_req = 1'b1;
    @(posedge clk_50);
    #1 io.repeat_req = 1'b0;
    watch_frame(32'h0, 1, 0, 0, 0, 0);
`endif

    check_val("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
